mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS-32 datapath.
- Sequences instruction fetch, decode, execute, memory and writeback over the single shared ALU, memory port and register file.
- Drives ALUOp to ALU_Control: 00 = add, 01 = subtract, 10 = decode function field.
- Also drives all datapath mux selects and write enables, and stalls on a memory-ready handshake.

Parameters:
- MEM_WAIT_LIMIT, 15: maximum cycles spent waiting for mem_ready in any one memory state before timeout; 0 disables the timeout.
- WAIT_CNT_W, 4: width of the wait counter; must satisfy 2^WAIT_CNT_W > MEM_WAIT_LIMIT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instruction[31:26] from the IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory has completed the current read/write this cycle
- ALUOp  output  2  to ALU_Control
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PCWrite  output  1  unconditional PC write
- PCWriteCond  output  1  PC write if zero
- IorD  output  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  IR load
- MemtoReg  output  1  register write data: 1 = MDR, 0 = ALUOut
- RegDst  output  1  1 = rd, 0 = rt
- RegWrite  output  1  register file write
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- mem_timeout  output  1  sticky flag, cleared only by reset
- state  output  4  current state, for debug

Behaviour:
- Outputs are a Moore decode of the registered state. Exception: PCWrite and IRWrite in FETCH, and the exit of every memory state, are qualified by mem_ready.
- Reset: state = FETCH (0), mem_timeout = 0, wait counter = 0. During reset all enables read 0; mux selects and ALUOp are 0.
- FETCH (0):
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - Holds until mem_ready. On the mem_ready cycle, IRWrite=1 and PCWrite=1, then go to DECODE.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target). Dispatch on opcode:
  - 100011 (lw) and 101011 (sw) → MEMADR
  - 000000 → RTYPE_EX
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EX
  - anything else → ILLEGAL handling (see Optional Feature)
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if lw, MEMWR if sw.
- MEMRD (3): MemRead=1, IorD=1. Hold until mem_ready, then go to MEMWB.
- MEMWB (4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Go to FETCH.
- MEMWR (5): MemWrite=1, IorD=1. Hold until mem_ready. On the mem_ready cycle, instr_done=1, then go to FETCH.
- RTYPE_EX (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RTYPE_WB.
- RTYPE_WB (7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Go to FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Go to FETCH.
- JUMP (9): PCWrite=1, PCSource=10, instr_done=1. Go to FETCH.
- ADDI_EX (10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDI_WB.
- ADDI_WB (11): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Go to FETCH.
- TRAP (12): all enables 0. Held until reset.
- Unused codes 13-15: go to FETCH next cycle, all enables 0.
- Wait counter:
  - Clears on entry to every state; increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - If MEM_WAIT_LIMIT≠0 and the counter reaches MEM_WAIT_LIMIT with mem_ready still 0: set mem_timeout, deassert requests, go to FETCH next cycle. No register or PC write occurs.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction: FETCH on the next edge, no writes issued in that cycle.

Optional Feature:
- Macro: MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE goes to TRAP (12), which holds until reset; the output illegal_op (1 bit, added to the port list) = 1 while in TRAP.
- Undefined: an illegal opcode is a NOP. DECODE goes to FETCH with instr_done=1; state 12 is unreachable and the illegal_op port does not exist.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings ST_FETCH … ST_TRAP
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp constants ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10
  - ALUSrcB and PCSource select constants
- One sub-module: mips_ctrl_wait_timer (wait counter plus timeout compare), instantiated once.

Test Plan:
- add R-type (opcode 000000), mem_ready=1 at the first FETCH cycle → states 0,1,6,7,0; ALUOp=10 in state 6; RegWrite=1 with RegDst=1 in state 7; instr_done pulses once.
- lw with mem_ready delayed 3 cycles in MEMRD → MemRead held for 4 cycles with IorD=1; MEMWB asserts RegWrite=1 and MemtoReg=1; total 8 cycles.
- beq with zero=1, then with zero=0 → PCWriteCond=1, ALUOp=01, PCSource=01 in state 8 in both cases; PCWrite=0 throughout BRANCH.
- mem_ready held 0 in FETCH with MEM_WAIT_LIMIT=15 → after 15 waiting cycles mem_timeout=1 and IRWrite never asserted; flag stays 1 until reset.
- opcode 111111 → with the macro: state 12 and illegal_op=1 persist across 20 cycles. Without: next state is 0 and instr_done=1.
- reset asserted during MEMWR with mem_ready=1 → no MemWrite on the following cycle; state=0, all enables 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-32 main control FSM.
// Holds the state encoding, the opcode constants, the ALUOp / ALUSrcB /
// PCSource select codes and the packed control-word payload that the FSM
// decodes each cycle.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_RTYPE_EX = 4'd6,
    ST_RTYPE_WB = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_ADDI_EX  = 4'd10,
    ST_ADDI_WB  = 4'd11,
    ST_TRAP     = 4'd12
  } state_e;

  // Opcode field, instruction[31:26]
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  // ALUOp to ALU_Control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB mux selects
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource mux selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control word driven to the datapath each cycle
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       instr_done;
  } ctrl_t;

  // States that issue a memory request and stall on mem_ready
  function automatic logic is_mem_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mips_ctrl_wait_timer.sv
// Memory wait counter with timeout compare and sticky timeout flag.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   count_en_i   - FSM is in a memory state and mem_ready is low
//   expired_c    - combinational: wait limit reached this cycle
//   timeout_o    - registered sticky timeout flag, cleared only by reset
// The counter is held at zero whenever count_en_i is low; since a memory
// state is only left on mem_ready or timeout, this clears it on every entry.
module mips_ctrl_wait_timer #(
  parameter int unsigned MEM_WAIT_LIMIT = 15,
  parameter int unsigned WAIT_CNT_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en_i,
  output logic expired_c,
  output logic timeout_o
);

  localparam logic                  LIMIT_EN = (MEM_WAIT_LIMIT != 32'd0);
  localparam logic [WAIT_CNT_W-1:0] LIMIT    = WAIT_CNT_W'(MEM_WAIT_LIMIT);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

  assign expired_c = LIMIT_EN && count_en_i && (cnt_q == LIMIT);

  // Next counter / flag values
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q | expired_c;
    if (count_en_i && !expired_c) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-32 datapath.
// Sequences fetch / decode / execute / memory / writeback over the shared
// ALU, memory port and register file; outputs are a decode of the state
// register, with FETCH writes and memory-state exits qualified by mem_ready.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   opcode, zero        - IR opcode field, ALU zero flag
//   mem_ready           - memory completes the current access this cycle
//   ALUOp..RegWrite     - datapath mux selects and write enables
//   instr_done          - pulse on the last cycle of each instruction
//   mem_timeout         - sticky memory-wait timeout flag
//   illegal_op          - in TRAP (only with MIPS_CTRL_ILLEGAL_TRAP_EN)
//   state               - current state, for debug
// Build option MIPS_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap in state 12
// until reset; otherwise they retire as a NOP from DECODE.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_LIMIT = 15,
  parameter int unsigned WAIT_CNT_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [1:0]          ALUOp,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                instr_done,
  output logic                mem_timeout,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  output logic                illegal_op,
`endif
  output logic [STATE_W-1:0]  state
);

  state_e state_q, state_d;
  ctrl_t  ctrl_c;
  logic   waiting_c;
  logic   expired_c;

  // The zero flag gates PCWriteCond inside the datapath, not here
  logic unused_zero;
  assign unused_zero = zero;

  assign waiting_c = is_mem_state(state_q) && !mem_ready;

  mips_ctrl_wait_timer #(
    .MEM_WAIT_LIMIT (MEM_WAIT_LIMIT),
    .WAIT_CNT_W     (WAIT_CNT_W)
  ) u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .count_en_i (waiting_c),
    .expired_c  (expired_c),
    .timeout_o  (mem_timeout)
  );

  // Next state and control-word decode
  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALUOP_ADD;
        ctrl_c.pc_source = PCSRC_ALU;
        if (mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = ST_DECODE;
        end else if (expired_c) begin
          ctrl_c.mem_read = 1'b0;
          state_d         = ST_FETCH;
        end
      end
      ST_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode resolves
        ctrl_c.alu_src_b = SRCB_IMM_SH2;
        ctrl_c.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_RTYPE_EX;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EX;
          default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            state_d = ST_TRAP;
`else
            ctrl_c.instr_done = 1'b1;
            state_d           = ST_FETCH;
`endif
          end
        endcase
      end
      ST_MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
        state_d          = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = ST_MEMWB;
        end else if (expired_c) begin
          ctrl_c.mem_read = 1'b0;
          state_d         = ST_FETCH;
        end
      end
      ST_MEMWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = ST_FETCH;
      end
      ST_MEMWR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.i_or_d    = 1'b1;
        if (mem_ready) begin
          ctrl_c.instr_done = 1'b1;
          state_d           = ST_FETCH;
        end else if (expired_c) begin
          ctrl_c.mem_write = 1'b0;
          state_d          = ST_FETCH;
        end
      end
      ST_RTYPE_EX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_B;
        ctrl_c.alu_op    = ALUOP_FUNCT;
        state_d          = ST_RTYPE_WB;
      end
      ST_RTYPE_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = ST_FETCH;
      end
      ST_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_B;
        ctrl_c.alu_op        = ALUOP_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
        ctrl_c.instr_done    = 1'b1;
        state_d              = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.pc_source  = PCSRC_JUMP;
        ctrl_c.instr_done = 1'b1;
        state_d           = ST_FETCH;
      end
      ST_ADDI_EX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
        state_d          = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = ST_FETCH;
      end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_FETCH;
    endcase
    // Reset is synchronous, so suppress writes in the cycle it is sampled
    if (reset) begin
      ctrl_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign ALUOp       = ctrl_c.alu_op;
  assign ALUSrcA     = ctrl_c.alu_src_a;
  assign ALUSrcB     = ctrl_c.alu_src_b;
  assign PCSource    = ctrl_c.pc_source;
  assign PCWrite     = ctrl_c.pc_write;
  assign PCWriteCond = ctrl_c.pc_write_cond;
  assign IorD        = ctrl_c.i_or_d;
  assign MemRead     = ctrl_c.mem_read;
  assign MemWrite    = ctrl_c.mem_write;
  assign IRWrite     = ctrl_c.ir_write;
  assign MemtoReg    = ctrl_c.mem_to_reg;
  assign RegDst      = ctrl_c.reg_dst;
  assign RegWrite    = ctrl_c.reg_write;
  assign instr_done  = ctrl_c.instr_done;
  assign state       = state_q;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = (state_q == ST_TRAP);
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-accurate scoreboard bench for mips_multicycle_ctrl.
// Each driven cycle pushes its expected state and control word; a negedge
// monitor pops and compares against the DUT outputs.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_ILL  = 6'b111111;

  typedef struct packed {
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       done;
    logic       tmo;
    logic       ill;
  } tb_ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    tb_ctrl_t   c;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, instr_done, mem_timeout;
  logic [3:0] state;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int    n_run  = 0;
  int    n_fail = 0;
  logic  exp_tmo;
  logic  z_val;
  exp_t  sb_q[$];
  string tag_q[$];
  exp_t  mon_e, mon_o;
  string mon_tag;

  mips_multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .ALUOp       (ALUOp),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .instr_done  (instr_done),
    .mem_timeout (mem_timeout),
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    .illegal_op  (illegal_op),
`endif
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Expected control words, one per state, taken from the state table
  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e       = '0;
    e.st    = st;
    e.c.tmo = exp_tmo;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    e.c.ill = (st == 4'd12);
`endif
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic rdy);
    exp_t e = mk(4'd0);
    e.c.mr = 1'b1; e.c.srcb = 2'b01; e.c.irw = rdy; e.c.pcw = rdy;
    return e;
  endfunction

  function automatic exp_t e_decode(input logic done);
    exp_t e = mk(4'd1);
    e.c.srcb = 2'b11; e.c.done = done;
    return e;
  endfunction

  function automatic exp_t e_memadr();
    exp_t e = mk(4'd2);
    e.c.srca = 1'b1; e.c.srcb = 2'b10;
    return e;
  endfunction

  function automatic exp_t e_memrd();
    exp_t e = mk(4'd3);
    e.c.mr = 1'b1; e.c.iord = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_memwb();
    exp_t e = mk(4'd4);
    e.c.rw = 1'b1; e.c.m2r = 1'b1; e.c.done = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_memwr(input logic rdy);
    exp_t e = mk(4'd5);
    e.c.mw = 1'b1; e.c.iord = 1'b1; e.c.done = rdy;
    return e;
  endfunction

  function automatic exp_t e_rtex();
    exp_t e = mk(4'd6);
    e.c.srca = 1'b1; e.c.aluop = 2'b10;
    return e;
  endfunction

  function automatic exp_t e_rtwb();
    exp_t e = mk(4'd7);
    e.c.rw = 1'b1; e.c.rdst = 1'b1; e.c.done = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_branch();
    exp_t e = mk(4'd8);
    e.c.srca = 1'b1; e.c.aluop = 2'b01; e.c.pcwc = 1'b1;
    e.c.pcsrc = 2'b01; e.c.done = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_jump();
    exp_t e = mk(4'd9);
    e.c.pcw = 1'b1; e.c.pcsrc = 2'b10; e.c.done = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_addiex();
    exp_t e = mk(4'd10);
    e.c.srca = 1'b1; e.c.srcb = 2'b10;
    return e;
  endfunction

  function automatic exp_t e_addiwb();
    exp_t e = mk(4'd11);
    e.c.rw = 1'b1; e.c.done = 1'b1;
    return e;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(1, 0));
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show in it
  task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                     input logic rst, input exp_t e);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = rdy;
    reset     = rst;
    zero      = z_val;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Scoreboard monitor, sampling mid-cycle
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e         = sb_q.pop_front();
      mon_tag       = tag_q.pop_front();
      mon_o         = '0;
      mon_o.st      = state;
      mon_o.c.aluop = ALUOp;
      mon_o.c.srca  = ALUSrcA;
      mon_o.c.srcb  = ALUSrcB;
      mon_o.c.pcsrc = PCSource;
      mon_o.c.pcw   = PCWrite;
      mon_o.c.pcwc  = PCWriteCond;
      mon_o.c.iord  = IorD;
      mon_o.c.mr    = MemRead;
      mon_o.c.mw    = MemWrite;
      mon_o.c.irw   = IRWrite;
      mon_o.c.m2r   = MemtoReg;
      mon_o.c.rdst  = RegDst;
      mon_o.c.rw    = RegWrite;
      mon_o.c.done  = instr_done;
      mon_o.c.tmo   = mem_timeout;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      mon_o.c.ill   = illegal_op;
`endif
      check({mon_tag, "/state"}, 32'(mon_o.st), 32'(mon_e.st));
      check({mon_tag, "/ctrl"}, 32'(mon_o.c), 32'(mon_e.c));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset     = 1'b1;
    opcode    = OPC_R;
    mem_ready = 1'b0;
    zero      = 1'b0;
    z_val     = 1'b0;
    exp_tmo   = 1'b0;

    cyc("rst_a", OPC_R, 1'b0, 1'b1, mk(4'd0));
    cyc("rst_b", OPC_R, 1'b1, 1'b1, mk(4'd0));

    // R-type, memory ready on the first fetch cycle
    cyc("r_fetch", OPC_R, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("r_dec",   OPC_R, rnd(), 1'b0, e_decode(1'b0));
    cyc("r_ex",    OPC_R, rnd(), 1'b0, e_rtex());
    cyc("r_wb",    OPC_R, rnd(), 1'b0, e_rtwb());

    // lw with three wait cycles in MEMRD
    cyc("lw_fetch", OPC_LW, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("lw_dec",   OPC_LW, rnd(), 1'b0, e_decode(1'b0));
    cyc("lw_adr",   OPC_LW, rnd(), 1'b0, e_memadr());
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", OPC_LW, 1'b0, 1'b0, e_memrd());
    cyc("lw_rd_go", OPC_LW, 1'b1, 1'b0, e_memrd());
    cyc("lw_wb",    OPC_LW, rnd(), 1'b0, e_memwb());

    // sw with a stalled fetch and two wait cycles in MEMWR
    cyc("sw_fetch_wait", OPC_SW, 1'b0, 1'b0, e_fetch(1'b0));
    cyc("sw_fetch",      OPC_SW, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("sw_dec",        OPC_SW, rnd(), 1'b0, e_decode(1'b0));
    cyc("sw_adr",        OPC_SW, rnd(), 1'b0, e_memadr());
    for (int i = 0; i < 2; i++) cyc("sw_wr_wait", OPC_SW, 1'b0, 1'b0, e_memwr(1'b0));
    cyc("sw_wr_go",      OPC_SW, 1'b1, 1'b0, e_memwr(1'b1));

    // beq taken, then not taken: same control either way
    for (int z = 1; z >= 0; z--) begin
      z_val = 1'(z);
      cyc("beq_fetch", OPC_BEQ, 1'b1, 1'b0, e_fetch(1'b1));
      cyc("beq_dec",   OPC_BEQ, rnd(), 1'b0, e_decode(1'b0));
      cyc("beq_br",    OPC_BEQ, rnd(), 1'b0, e_branch());
    end
    z_val = 1'b0;

    // jump and addi
    cyc("j_fetch",    OPC_J, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("j_dec",      OPC_J, rnd(), 1'b0, e_decode(1'b0));
    cyc("j_jmp",      OPC_J, rnd(), 1'b0, e_jump());
    cyc("addi_fetch", OPC_ADDI, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("addi_dec",   OPC_ADDI, rnd(), 1'b0, e_decode(1'b0));
    cyc("addi_ex",    OPC_ADDI, rnd(), 1'b0, e_addiex());
    cyc("addi_wb",    OPC_ADDI, rnd(), 1'b0, e_addiwb());

    // illegal opcode
    cyc("ill_fetch", OPC_ILL, 1'b1, 1'b0, e_fetch(1'b1));
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    cyc("ill_dec", OPC_ILL, rnd(), 1'b0, e_decode(1'b0));
    for (int i = 0; i < 20; i++) cyc("ill_trap", OPC_ILL, rnd(), 1'b0, mk(4'd12));
    cyc("ill_rst", OPC_ILL, 1'b1, 1'b1, mk(4'd12));
`else
    cyc("ill_dec", OPC_ILL, rnd(), 1'b0, e_decode(1'b1));
`endif

    // fetch timeout: 15 counted waits, expiry on the 16th cycle
    for (int i = 0; i < 15; i++) cyc("to_wait", OPC_R, 1'b0, 1'b0, e_fetch(1'b0));
    e        = mk(4'd0);
    e.c.srcb = 2'b01;
    cyc("to_expire", OPC_R, 1'b0, 1'b0, e);
    exp_tmo = 1'b1;
    for (int i = 0; i < 2; i++) cyc("to_sticky", OPC_R, 1'b0, 1'b0, e_fetch(1'b0));
    cyc("to_r_fetch", OPC_R, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("to_r_dec",   OPC_R, rnd(), 1'b0, e_decode(1'b0));
    cyc("to_r_ex",    OPC_R, rnd(), 1'b0, e_rtex());
    cyc("to_r_wb",    OPC_R, rnd(), 1'b0, e_rtwb());

    // reset while MEMWR sees mem_ready
    cyc("rs_fetch", OPC_SW, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("rs_dec",   OPC_SW, rnd(), 1'b0, e_decode(1'b0));
    cyc("rs_adr",   OPC_SW, rnd(), 1'b0, e_memadr());
    cyc("rs_memwr", OPC_SW, 1'b1, 1'b1, mk(4'd5));
    exp_tmo = 1'b0;
    cyc("rs_hold",  OPC_SW, 1'b1, 1'b1, mk(4'd0));
    cyc("post_fetch", OPC_J, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("post_dec",   OPC_J, rnd(), 1'b0, e_decode(1'b0));
    cyc("post_jmp",   OPC_J, rnd(), 1'b0, e_jump());

    repeat (2) @(posedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
